regfile_port_sched: RTL and testbench

Two-requester scheduler for the 16 x 8-bit register group (one write port, two read ports). Arbitrates the core pipeline (requester A) against the debug/loader path (requester B), registers the granted command onto the register-group ports, and returns registered read data with a valid strobe. A has fixed priority, and a starvation counter guarantees B forward progress.

---
 rtl/regfile_port_sched_pkg.sv | 29 ++
 rtl/regfile_port_sched_starve_ctr.sv | 29 ++
 rtl/regfile_port_sched.sv | 147 ++++++++++++++
 tb/tb_regfile_port_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_port_sched_pkg.sv
// Shared types for the register-group port scheduler.
// Command bundle, owner ids and address range helper.
package regfile_sched_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    owner_t            owner;
  } rf_cmd_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr < REG_LIMIT;
  endfunction

endpackage

// File: rtl/regfile_port_sched_starve_ctr.sv
// Saturating starvation counter for the low-priority requester.
// at_limit forces the next contended grant to B.
module rf_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIM) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/regfile_port_sched.sv
// Two-requester scheduler for the 16x8 register group.
// Fixed priority to A, starvation guard for B, 2-cycle latency.
module regfile_port_sched
  import regfile_sched_pkg::*;
#(
  parameter int    UUID         = 0,
  parameter string NAME         = "",
  parameter int    STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [ADDR_W-1:0] a_raddr1,
  input  logic [ADDR_W-1:0] a_raddr2,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata1,
  output logic [DATA_W-1:0] a_rdata2,
  output logic              a_err,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_waddr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [ADDR_W-1:0] b_raddr1,
  input  logic [ADDR_W-1:0] b_raddr2,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata1,
  output logic [DATA_W-1:0] b_rdata2,
  output logic              b_err,
  output logic [ADDR_W-1:0] rf_in_addr,
  output logic              rf_en_in,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [ADDR_W-1:0] rf_out_addr1,
  output logic [ADDR_W-1:0] rf_out_addr2,
  input  logic [DATA_W-1:0] rf_data_out1,
  input  logic [DATA_W-1:0] rf_data_out2
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT out of range");
  end
  if (UUID < 0) begin : g_bad_uuid
    $error("UUID must be non-negative");
  end

  logic    at_limit;
  logic    a_acc;
  logic    b_acc;
  logic    cmd_valid;
  rf_cmd_t cmd;
  rf_cmd_t cmd_d;

  assign a_ready = rst & a_valid & ~(b_valid & at_limit);
  assign b_ready = rst & b_valid & (~a_valid | at_limit);
  assign a_acc   = a_valid & a_ready;
  assign b_acc   = b_valid & b_ready;

  rf_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (b_valid & ~b_ready),
    .clr     (b_acc | ~b_valid),
    .at_limit(at_limit)
  );

  always_comb begin
    cmd_d = cmd;
    unique case (1'b1)
      a_acc: cmd_d = '{we: a_we, waddr: a_waddr,
                       wdata: a_wdata, raddr1: a_raddr1,
                       raddr2: a_raddr2, owner: OWN_A};
      b_acc: cmd_d = '{we: b_we, waddr: b_waddr,
                       wdata: b_wdata, raddr1: b_raddr1,
                       raddr2: b_raddr2, owner: OWN_B};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid <= 1'b0;
      cmd       <= '0;
    end else begin
      cmd_valid <= a_acc | b_acc;
      cmd       <= cmd_d;
    end
  end

  logic              w_ok;
  logic              r1_ok;
  logic              r2_ok;
  logic              cmd_err;
  logic              own_a;
  logic              own_b;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign w_ok    = in_range(cmd.waddr);
  assign r1_ok   = in_range(cmd.raddr1);
  assign r2_ok   = in_range(cmd.raddr2);
  assign cmd_err = (cmd.we & ~w_ok) | ~r1_ok | ~r2_ok;
  assign own_a   = cmd_valid & (cmd.owner == OWN_A);
  assign own_b   = cmd_valid & (cmd.owner == OWN_B);

  assign rf_in_addr   = cmd.waddr;
  assign rf_data_in   = cmd.wdata;
  assign rf_en_in     = cmd_valid & cmd.we & w_ok;
  assign rf_out_addr1 = cmd.raddr1;
  assign rf_out_addr2 = cmd.raddr2;

  // Out-of-range reads return zero rather than whatever the group drives.
  assign rd1 = r1_ok ? rf_data_out1 : '0;
  assign rd2 = r2_ok ? rf_data_out2 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rdata1 <= '0;
      a_rdata2 <= '0;
      b_rdata1 <= '0;
      b_rdata2 <= '0;
    end else begin
      a_rvalid <= own_a;
      b_rvalid <= own_b;
      a_err    <= own_a & cmd_err;
      b_err    <= own_b & cmd_err;
      if (own_a) begin
        a_rdata1 <= rd1;
        a_rdata2 <= rd2;
      end
      if (own_b) begin
        b_rdata1 <= rd1;
        b_rdata2 <= rd2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a transaction-level model
// and a stub 16x8 register group.
module tb_regfile_port_sched;

  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid, a_we, b_valid, b_we;
  logic [7:0] a_waddr, a_wdata, a_raddr1, a_raddr2;
  logic [7:0] b_waddr, b_wdata, b_raddr1, b_raddr2;
  logic       a_ready, a_rvalid, a_err;
  logic       b_ready, b_rvalid, b_err;
  logic [7:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic [7:0] rf_in_addr, rf_data_in, rf_out_addr1, rf_out_addr2;
  logic       rf_en_in;
  logic [7:0] rf_data_out1, rf_data_out2;

  logic [7:0] stub [16] = '{default: 8'h00};

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regfile_port_sched #(
    .UUID(1),
    .NAME("tb"),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
    .a_waddr(a_waddr), .a_wdata(a_wdata),
    .a_raddr1(a_raddr1), .a_raddr2(a_raddr2),
    .a_rvalid(a_rvalid), .a_rdata1(a_rdata1),
    .a_rdata2(a_rdata2), .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
    .b_waddr(b_waddr), .b_wdata(b_wdata),
    .b_raddr1(b_raddr1), .b_raddr2(b_raddr2),
    .b_rvalid(b_rvalid), .b_rdata1(b_rdata1),
    .b_rdata2(b_rdata2), .b_err(b_err),
    .rf_in_addr(rf_in_addr), .rf_en_in(rf_en_in),
    .rf_data_in(rf_data_in),
    .rf_out_addr1(rf_out_addr1), .rf_out_addr2(rf_out_addr2),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2)
  );

  // Stub register group: 4-bit decode, combinational read.
  assign rf_data_out1 = (rf_out_addr1 < 8'd16) ?
                        stub[rf_out_addr1[3:0]] : 8'hEE;
  assign rf_data_out2 = (rf_out_addr2 < 8'd16) ?
                        stub[rf_out_addr2[3:0]] : 8'hEE;
  always @(posedge clk)
    if (rf_en_in) stub[rf_in_addr[3:0]] <= rf_data_in;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    bit v; bit own; bit we;
    int waddr; int wdata; int raddr1; int raddr2;
  } mcmd_t;
  typedef struct {
    bit v; bit own; bit err;
  } mresp_t;

  int     m_mem [16] = '{default: 0};
  int     m_cnt = 0;
  mcmd_t  s1 = '{default: 0};
  mresp_t s2 = '{default: 0};
  int     held_a1 = 0, held_a2 = 0, held_b1 = 0, held_b2 = 0;

  function automatic bit grant_a(input bit av, input bit bv, input int c);
    return av && !(bv && c == LIM);
  endfunction
  function automatic bit grant_b(input bit av, input bit bv, input int c);
    return bv && (!av || c == LIM);
  endfunction
  function automatic int rdv(input int addr);
    return (addr < 16) ? m_mem[addr] : 0;
  endfunction
  function automatic bit cerr(input mcmd_t c);
    return (c.we && c.waddr >= 16) || c.raddr1 >= 16 || c.raddr2 >= 16;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '{default: 0};
      s2      <= '{default: 0};
      m_cnt   <= 0;
      held_a1 <= 0; held_a2 <= 0;
      held_b1 <= 0; held_b2 <= 0;
    end else begin
      s2 <= '{v: s1.v, own: s1.own, err: s1.v && cerr(s1)};
      if (s1.v && s1.we && s1.waddr < 16)
        m_mem[s1.waddr] <= s1.wdata;
      if (s1.v && !s1.own) begin
        held_a1 <= rdv(s1.raddr1); held_a2 <= rdv(s1.raddr2);
      end
      if (s1.v && s1.own) begin
        held_b1 <= rdv(s1.raddr1); held_b2 <= rdv(s1.raddr2);
      end
      if (grant_a(a_valid, b_valid, m_cnt))
        s1 <= '{v: 1'b1, own: 1'b0, we: a_we,
                waddr: int'(a_waddr), wdata: int'(a_wdata),
                raddr1: int'(a_raddr1), raddr2: int'(a_raddr2)};
      else if (grant_b(a_valid, b_valid, m_cnt))
        s1 <= '{v: 1'b1, own: 1'b1, we: b_we,
                waddr: int'(b_waddr), wdata: int'(b_wdata),
                raddr1: int'(b_raddr1), raddr2: int'(b_raddr2)};
      else
        s1 <= '{default: 0};
      if (b_valid && !grant_b(a_valid, b_valid, m_cnt))
        m_cnt <= (m_cnt < LIM) ? m_cnt + 1 : LIM;
      else
        m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    chk("a_ready", a_ready, rst && grant_a(a_valid, b_valid, m_cnt));
    chk("b_ready", b_ready, rst && grant_b(a_valid, b_valid, m_cnt));
    chk("a_rvalid", a_rvalid, s2.v && !s2.own);
    chk("b_rvalid", b_rvalid, s2.v && s2.own);
    chk("a_err", a_err, s2.v && !s2.own && s2.err);
    chk("b_err", b_err, s2.v && s2.own && s2.err);
    chk("a_rdata1", a_rdata1, held_a1);
    chk("a_rdata2", a_rdata2, held_a2);
    chk("b_rdata1", b_rdata1, held_b1);
    chk("b_rdata2", b_rdata2, held_b2);
    chk("rf_en_in", rf_en_in, s1.v && s1.we && s1.waddr < 16);
    if (!rst) begin
      chk("rst_in_addr", rf_in_addr, 0);
      chk("rst_data_in", rf_data_in, 0);
      chk("rst_out_addr1", rf_out_addr1, 0);
      chk("rst_out_addr2", rf_out_addr2, 0);
    end else if (s1.v) begin
      chk("rf_in_addr", rf_in_addr, s1.waddr);
      chk("rf_data_in", rf_data_in, s1.wdata);
      chk("rf_out_addr1", rf_out_addr1, s1.raddr1);
      chk("rf_out_addr2", rf_out_addr2, s1.raddr2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_we = 1'b0;
    b_valid = 1'b0; b_we = 1'b0;
  endtask

  task automatic set_a(input bit we, input logic [7:0] wa,
                       input logic [7:0] wd, input logic [7:0] r1,
                       input logic [7:0] r2);
    a_valid = 1'b1; a_we = we; a_waddr = wa;
    a_wdata = wd; a_raddr1 = r1; a_raddr2 = r2;
  endtask

  task automatic set_b(input bit we, input logic [7:0] wa,
                       input logic [7:0] wd, input logic [7:0] r1,
                       input logic [7:0] r2);
    b_valid = 1'b1; b_we = we; b_waddr = wa;
    b_wdata = wd; b_raddr1 = r1; b_raddr2 = r2;
  endtask

  initial begin
    int na, nb, first_b, nr, nv;
    idle();
    a_waddr = '0; a_wdata = '0; a_raddr1 = '0; a_raddr2 = '0;
    b_waddr = '0; b_wdata = '0; b_raddr1 = '0; b_raddr2 = '0;

    // traffic presented while held in reset
    set_a(1'b1, 8'd1, 8'hAB, 8'd1, 8'd2);
    set_b(1'b0, 8'd0, 8'd0, 8'd3, 8'd4);
    repeat (3) step();
    chk("rst_a_ready_lit", a_ready, 0);
    chk("rst_rf_en_lit", rf_en_in, 0);
    idle();
    rst = 1'b1;

    // B writes r3 then reads it back
    set_b(1'b1, 8'd3, 8'h5A, 8'd3, 8'd0);
    step();
    set_b(1'b0, 8'd0, 8'd0, 8'd3, 8'd0);
    step();
    idle();
    chk("t1_rvalid1_lit", b_rvalid, 1);
    chk("t1_pre_write_lit", b_rdata1, 8'h00);
    step();
    chk("t1_rvalid2_lit", b_rvalid, 1);
    chk("t1_raw_lit", b_rdata1, 8'h5A);
    repeat (2) step();

    // contention: A wins LIM cycles, then B
    na = 0; nb = 0; first_b = -1;
    set_a(1'b0, 8'd0, 8'd0, 8'd1, 8'd2);
    set_b(1'b0, 8'd0, 8'd0, 8'd3, 8'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ready) na++;
      if (b_ready) begin
        nb++;
        if (first_b < 0) first_b = i;
      end
      step();
    end
    idle();
    chk("t2_a_grants_lit", na, 8);
    chk("t2_b_grants_lit", nb, 2);
    chk("t2_first_b_lit", first_b, 4);
    repeat (3) step();

    // same-command read of the register being written
    set_a(1'b1, 8'd2, 8'h11, 8'd2, 8'd2);
    step();
    set_a(1'b0, 8'd0, 8'd0, 8'd2, 8'd0);
    step();
    idle();
    chk("t3_rvalid_lit", a_rvalid, 1);
    chk("t3_pre_write_lit", a_rdata1, 8'h00);
    step();
    chk("t3_post_write_lit", a_rdata1, 8'h11);
    repeat (2) step();

    // out-of-range write and read
    set_b(1'b1, 8'h20, 8'hFF, 8'h10, 8'd3);
    step();
    idle();
    chk("t4_no_write_lit", rf_en_in, 0);
    step();
    chk("t4_err_lit", b_err, 1);
    chk("t4_rdata1_lit", b_rdata1, 8'h00);
    chk("t4_rdata2_lit", b_rdata2, 8'h5A);
    step();
    chk("t4_err_once_lit", b_err, 0);
    chk("t4_r0_intact_lit", stub[0], 8'h00);
    repeat (2) step();

    // reset while a write sits in stage C
    set_a(1'b1, 8'd5, 8'h77, 8'd5, 8'd0);
    step();
    idle();
    chk("t5_en_up_lit", rf_en_in, 1);
    #2 rst = 1'b0;
    #1 chk("t5_en_drop_lit", rf_en_in, 0);
    step();
    step();
    chk("t5_no_rvalid_lit", a_rvalid, 0);
    chk("t5_r5_intact_lit", stub[5], 8'h00);
    rst = 1'b1;
    step();

    // throughput: 8 writes then 8 reads from A
    nr = 0; nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 8)
        set_a(1'b1, 8'(i), 8'(8'h30 + i), 8'(i), 8'd15);
      else if (i < 16)
        set_a(1'b0, 8'd0, 8'd0, 8'(i - 8), 8'((i - 7) % 8));
      else
        idle();
      @(negedge clk);
      if (a_ready) nr++;
      if (a_rvalid) nv++;
      step();
    end
    chk("t6_ready_cnt_lit", nr, 16);
    chk("t6_rvalid_cnt_lit", nv, 16);
    chk("t6_last_read_lit", a_rdata1, 8'h37);
    chk("t6_last_read2_lit", a_rdata2, 8'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
